// File: rtl/uart_pkg.sv
// Types and constants shared by the UART transmitter and receiver.
package uart_pkg;

  localparam int UART_DATA_W = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_t;

endpackage

// File: rtl/uart_tx_if.sv
// Producer-side handshake into the UART transmitter.
interface uart_tx_if;
  import uart_pkg::*;

  logic [UART_DATA_W-1:0] tx_data;
  logic                   tx_valid;
  logic                   tx_ready;

  modport master (output tx_data, output tx_valid, input tx_ready);
  modport slave  (input tx_data, input tx_valid, output tx_ready);

endinterface

// File: rtl/uart_tx_fifo.sv
// First-word-fall-through FIFO decoupling the producer from the bit rate.
module uart_tx_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     uart_clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  // A full FIFO refuses pushes even if a pop frees a slot in the same cycle.
  assign full    = (count == (PW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge uart_clk) begin
    if (do_push) begin
      mem[wr_ptr] <= din;
    end
  end

  always_ff @(posedge uart_clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: start bit, 8 data bits LSB first, STOP_BITS stop bits,
// each bit held CLOCK_MULTIPLE clocks; bytes are queued in a small FIFO.
module uart_tx
  import uart_pkg::*;
#(
  parameter int CLOCK_MULTIPLE = 4,
  parameter int STOP_BITS      = 1,
  parameter int FIFO_DEPTH     = 4
) (
  input  logic                          uart_clk,
  input  logic                          reset,
  uart_tx_if.slave                      tx_if,
  output logic                          uart_out,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int BW = $clog2(CLOCK_MULTIPLE);
  localparam logic [BW-1:0] BAUD_MAX  = BW'(CLOCK_MULTIPLE - 1);
  localparam logic          STOP_LAST = 1'(STOP_BITS - 1);

  localparam logic [1:0] ST_IDLE  = IDLE;
  localparam logic [1:0] ST_START = START;
  localparam logic [1:0] ST_DATA  = DATA;
  localparam logic [1:0] ST_STOP  = STOP;

  logic [1:0]             state;
  logic [BW-1:0]          baud_cnt;
  logic [2:0]             bit_cnt;
  logic                   stop_cnt;
  logic [UART_DATA_W-1:0] shift_reg;
  logic [UART_DATA_W-1:0] fifo_dout;
  logic                   fifo_full;
  logic                   fifo_empty;
  logic                   baud_done;
  logic                   frame_end;
  logic                   pop;

  uart_tx_fifo #(
    .WIDTH (UART_DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .uart_clk (uart_clk),
    .reset    (reset),
    .push     (tx_if.tx_valid),
    .pop      (pop),
    .din      (tx_if.tx_data),
    .dout     (fifo_dout),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .count    (fifo_count)
  );

  assign tx_if.tx_ready = !fifo_full;
  assign baud_done      = (baud_cnt == '0);
  assign frame_end      = (state == ST_STOP) && baud_done && (stop_cnt == STOP_LAST);
  assign pop            = !fifo_empty && ((state == ST_IDLE) || frame_end);

  // The line and busy flops follow the state one clock later, so the line
  // is a clean register output and busy falls right after the last stop bit.
  always_ff @(posedge uart_clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      baud_cnt  <= '0;
      bit_cnt   <= '0;
      stop_cnt  <= 1'b0;
      shift_reg <= '0;
      uart_out  <= 1'b1;
      busy      <= 1'b0;
    end else begin
      busy <= (state != ST_IDLE) || !fifo_empty;
      case (state)
        ST_START: uart_out <= 1'b0;
        ST_DATA:  uart_out <= shift_reg[0];
        default:  uart_out <= 1'b1;
      endcase

      case (state)
        ST_IDLE: begin
          if (pop) begin
            shift_reg <= fifo_dout;
            baud_cnt  <= BAUD_MAX;
            state     <= ST_START;
          end
        end
        ST_START: begin
          if (baud_done) begin
            state    <= ST_DATA;
            bit_cnt  <= '0;
            baud_cnt <= BAUD_MAX;
          end else begin
            baud_cnt <= baud_cnt - 1'b1;
          end
        end
        ST_DATA: begin
          if (baud_done) begin
            shift_reg <= {1'b0, shift_reg[UART_DATA_W-1:1]};
            baud_cnt  <= BAUD_MAX;
            if (bit_cnt == 3'd7) begin
              state    <= ST_STOP;
              stop_cnt <= 1'b0;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end else begin
            baud_cnt <= baud_cnt - 1'b1;
          end
        end
        ST_STOP: begin
          if (baud_done) begin
            baud_cnt <= BAUD_MAX;
            if (stop_cnt == STOP_LAST) begin
              // A queued byte starts its frame with no idle gap.
              if (pop) begin
                shift_reg <= fifo_dout;
                state     <= ST_START;
              end else begin
                state <= ST_IDLE;
              end
            end else begin
              stop_cnt <= stop_cnt + 1'b1;
            end
          end else begin
            baud_cnt <= baud_cnt - 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: constant frame table, back-to-back, FIFO
// back-pressure, mid-frame reset, two stop bits and a randomized byte stream.
module tb_uart_tx;

  logic       uart_clk;
  logic       reset;
  logic       uart_out1, busy1;
  logic [2:0] fifo_count1;
  logic       uart_out2, busy2;
  logic [2:0] fifo_count2;

  uart_tx_if if1 ();
  uart_tx_if if2 ();

  uart_tx #(.CLOCK_MULTIPLE(4), .STOP_BITS(1), .FIFO_DEPTH(4)) dut1 (
    .uart_clk   (uart_clk),
    .reset      (reset),
    .tx_if      (if1.slave),
    .uart_out   (uart_out1),
    .busy       (busy1),
    .fifo_count (fifo_count1)
  );

  uart_tx #(.CLOCK_MULTIPLE(4), .STOP_BITS(2), .FIFO_DEPTH(4)) dut2 (
    .uart_clk   (uart_clk),
    .reset      (reset),
    .tx_if      (if2.slave),
    .uart_out   (uart_out2),
    .busy       (busy2),
    .fifo_count (fifo_count2)
  );

  typedef struct {
    logic [7:0] data;
    logic [9:0] frame;
  } vec_t;

  vec_t       vectors [5];
  int         check_count = 0;
  int         error_count = 0;
  int         cycle = 0;
  logic       mon_on = 1'b0;
  logic [7:0] exp_q [$];
  int         start_cycles [$];
  int         frames_seen = 0;

  initial begin
    uart_clk = 1'b0;
    forever #5 uart_clk = ~uart_clk;
  end

  initial begin
    forever begin
      @(posedge uart_clk);
      cycle++;
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    check_count++;
    if (actual !== expected) begin
      error_count++;
      $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, actual, expected, cycle);
    end
  endtask

  // One-cycle push into the single-stop-bit transmitter.
  task automatic applyStimulus(input logic [7:0] data);
    @(negedge uart_clk);
    if1.tx_data  = data;
    if1.tx_valid = 1'b1;
    @(posedge uart_clk);
    #1;
    if1.tx_valid = 1'b0;
  endtask

  task automatic waitDrain(input string name, input int limit);
    int n = 0;
    while (exp_q.size() != 0 && n < limit) begin
      @(posedge uart_clk);
      #1;
      n++;
    end
    checkOutput(name, exp_q.size(), 0);
    repeat (4) @(posedge uart_clk);
    #1;
  endtask

  // Line monitor: decodes each frame on dut1 and compares with the queue of pushed bytes.
  initial begin
    forever begin
      @(posedge uart_clk);
      #1;
      if (mon_on && !uart_out1) begin
        logic [9:0] seen;
        logic       glitch;
        int         c0;
        logic [7:0] exp_byte;
        seen   = '0;
        glitch = 1'b0;
        c0     = cycle;
        for (int c = 1; c < 40; c++) begin
          @(posedge uart_clk);
          #1;
          if (c % 4 == 0) seen[c/4] = uart_out1;
          else if (uart_out1 !== seen[c/4]) glitch = 1'b1;
        end
        start_cycles.push_back(c0);
        frames_seen++;
        checkOutput("frame_clean", glitch, 0);
        if (exp_q.size() == 0) begin
          checkOutput("unexpected_frame", seen, 0);
        end else begin
          exp_byte = exp_q.pop_front();
          checkOutput("frame_data", seen, {1'b1, exp_byte, 1'b0});
        end
      end
    end
  end

  initial begin
    int         t0;
    int         bad;
    int         i;
    int         guard;
    int         base;
    logic       rdy;
    logic       saw_full;
    logic       low_seen;
    logic       expv;
    logic [7:0] bytes [6];
    logic [7:0] b81;

    vectors[0] = '{data: 8'hA5, frame: 10'b1101001010};
    vectors[1] = '{data: 8'h00, frame: 10'b1000000000};
    vectors[2] = '{data: 8'hFF, frame: 10'b1111111110};
    vectors[3] = '{data: 8'h5A, frame: 10'b1010110100};
    vectors[4] = '{data: 8'h3C, frame: 10'b1001111000};

    if1.tx_data = '0; if1.tx_valid = 1'b0;
    if2.tx_data = '0; if2.tx_valid = 1'b0;
    reset = 1'b1;
    repeat (3) @(posedge uart_clk);
    #1;
    checkOutput("reset_uart_out", uart_out1, 1);
    checkOutput("reset_tx_ready", if1.tx_ready, 1);
    checkOutput("reset_busy", busy1, 0);
    checkOutput("reset_fifo_count", fifo_count1, 0);
    checkOutput("reset_uart_out2", uart_out2, 1);
    @(negedge uart_clk);
    reset = 1'b0;
    repeat (3) @(posedge uart_clk);
    #1;

    $display("[TB] table-driven single frames");
    for (int v = 0; v < 5; v++) begin
      applyStimulus(vectors[v].data);
      checkOutput("tbl_count_after_push", fifo_count1, 1);
      @(posedge uart_clk);
      #1;
      checkOutput("tbl_line_before_start", uart_out1, 1);
      bad = 0;
      for (int j = 0; j < 40; j++) begin
        @(posedge uart_clk);
        #1;
        if (uart_out1 !== vectors[v].frame[j/4]) bad++;
      end
      checkOutput("tbl_frame_bits", bad, 0);
      checkOutput("tbl_busy_last_stop", busy1, 1);
      @(posedge uart_clk);
      #1;
      checkOutput("tbl_busy_after_stop", busy1, 0);
      checkOutput("tbl_line_idle", uart_out1, 1);
    end

    $display("[TB] back-to-back frames");
    mon_on = 1'b1;
    start_cycles.delete();
    base = frames_seen;
    t0 = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge uart_clk);
      if1.tx_data  = (k == 0) ? 8'h00 : (k == 1) ? 8'hFF : 8'h5A;
      if1.tx_valid = 1'b1;
      exp_q.push_back(if1.tx_data);
      @(posedge uart_clk);
      #1;
      if (k == 0) t0 = cycle;
    end
    @(negedge uart_clk);
    if1.tx_valid = 1'b0;
    waitDrain("b2b_drain", 400);
    checkOutput("b2b_frames", frames_seen - base, 3);
    if (start_cycles.size() >= 3) begin
      checkOutput("b2b_latency", start_cycles[0] - t0, 2);
      checkOutput("b2b_period_1", start_cycles[1] - start_cycles[0], 40);
      checkOutput("b2b_period_2", start_cycles[2] - start_cycles[1], 40);
    end

    $display("[TB] held valid with back-pressure");
    for (int k = 0; k < 6; k++) bytes[k] = 8'($urandom);
    base = frames_seen;
    i = 0;
    guard = 0;
    saw_full = 1'b0;
    while (i < 6 && guard < 2000) begin
      @(negedge uart_clk);
      if1.tx_valid = 1'b1;
      if1.tx_data  = bytes[i];
      rdy = if1.tx_ready;
      if (fifo_count1 == 3'd4) begin
        saw_full = 1'b1;
        checkOutput("bp_ready_when_full", rdy, 0);
      end
      if (rdy) exp_q.push_back(bytes[i]);
      @(posedge uart_clk);
      if (rdy) i++;
      guard++;
    end
    @(negedge uart_clk);
    if1.tx_valid = 1'b0;
    checkOutput("bp_all_accepted", i, 6);
    checkOutput("bp_saw_full", saw_full, 1);
    waitDrain("bp_drain", 600);
    checkOutput("bp_frames", frames_seen - base, 6);

    $display("[TB] reset in the middle of a frame");
    mon_on = 1'b0;
    t0 = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge uart_clk);
      if1.tx_data  = (k == 0) ? 8'h3C : (k == 1) ? 8'h11 : 8'h22;
      if1.tx_valid = 1'b1;
      @(posedge uart_clk);
      #1;
      if (k == 0) t0 = cycle;
    end
    @(negedge uart_clk);
    if1.tx_valid = 1'b0;
    while (cycle < t0 + 19) begin
      @(posedge uart_clk);
      #1;
    end
    checkOutput("rst_bit3_value", uart_out1, 1);
    checkOutput("rst_queued", fifo_count1, 2);
    @(negedge uart_clk);
    reset = 1'b1;
    @(posedge uart_clk);
    #1;
    checkOutput("rst_line_high", uart_out1, 1);
    checkOutput("rst_fifo_flushed", fifo_count1, 0);
    checkOutput("rst_tx_ready", if1.tx_ready, 1);
    checkOutput("rst_busy", busy1, 0);
    @(negedge uart_clk);
    reset = 1'b0;
    low_seen = 1'b0;
    repeat (120) begin
      @(posedge uart_clk);
      #1;
      if (!uart_out1) low_seen = 1'b1;
    end
    checkOutput("rst_no_more_frames", low_seen, 0);

    $display("[TB] two stop bits");
    b81 = 8'h81;
    t0 = 0;
    for (int k = 0; k < 2; k++) begin
      @(negedge uart_clk);
      if2.tx_data  = b81;
      if2.tx_valid = 1'b1;
      @(posedge uart_clk);
      #1;
      if (k == 0) t0 = cycle;
    end
    @(negedge uart_clk);
    if2.tx_valid = 1'b0;
    guard = 0;
    while (uart_out2 && guard < 20) begin
      @(posedge uart_clk);
      #1;
      guard++;
    end
    checkOutput("stop2_start_seen", uart_out2, 0);
    checkOutput("stop2_latency", cycle - t0, 2);
    bad = 0;
    for (int j = 0; j < 88; j++) begin
      int k;
      if (j != 0) begin
        @(posedge uart_clk);
        #1;
      end
      k = (j % 44) / 4;
      if (k == 0)      expv = 1'b0;
      else if (k <= 8) expv = b81[k-1];
      else             expv = 1'b1;
      if (uart_out2 !== expv) bad++;
    end
    checkOutput("stop2_two_frames", bad, 0);
    @(posedge uart_clk);
    #1;
    checkOutput("stop2_busy_done", busy2, 0);

    $display("[TB] randomized byte stream");
    mon_on = 1'b1;
    base = frames_seen;
    i = 0;
    guard = 0;
    while (i < 40 && guard < 5000) begin
      logic v;
      @(negedge uart_clk);
      v = ($urandom_range(0, 3) != 0);
      if1.tx_valid = v;
      if1.tx_data  = 8'($urandom);
      rdy = if1.tx_ready;
      if (v && rdy) exp_q.push_back(if1.tx_data);
      @(posedge uart_clk);
      if (v && rdy) i++;
      guard++;
    end
    @(negedge uart_clk);
    if1.tx_valid = 1'b0;
    checkOutput("rand_all_accepted", i, 40);
    waitDrain("rand_drain", 2200);
    checkOutput("rand_frames", frames_seen - base, 40);
    checkOutput("rand_busy_idle", busy1, 0);
    checkOutput("rand_fifo_empty", fifo_count1, 0);
    mon_on = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", check_count, error_count);
    $finish;
  end

endmodule
